// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the 5-stage MIPS pipeline controller:
//   fwd_sel_t  - EXE operand forward-select encodings
//   state_t    - run-control FSM state encodings
//   fwd_select - per-operand forwarding priority (EXE over MEM over regfile)
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      FROM_REG        = 2'd0,
      FROM_EXE_ALUOUT = 2'd1,
      FROM_MEM_ALUOUT = 2'd2,
      FROM_MEM_DM     = 2'd3
   } fwd_sel_t;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2,
      ST_STEP = 2'd3
   } state_t;

   // A load still in EXE has no data yet, so it is never an EXE forward
   // source; that case is covered by the load-use stall instead.
   function automatic fwd_sel_t fwd_select(
      input logic       used,
      input logic [4:0] addr,
      input logic [4:0] regw_addr_exe,
      input logic       wb_wen_exe,
      input logic       mem_ren_exe,
      input logic [4:0] regw_addr_mem,
      input logic       wb_wen_mem,
      input logic       mem_ren_mem
   );
      fwd_sel_t sel;
      sel = FROM_REG;
      if (used && addr != 5'd0) begin
         if (addr == regw_addr_exe && wb_wen_exe && !mem_ren_exe)
            sel = FROM_EXE_ALUOUT;
         else if (addr == regw_addr_mem && wb_wen_mem)
            sel = mem_ren_mem ? FROM_MEM_DM : FROM_MEM_ALUOUT;
      end
      return sel;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_hazard_unit
// Purely combinational hazard detection for the instruction in ID.
// Inputs : ID source fields/usage, EXE and MEM destination info.
// Outputs: load_use  - ID must wait one cycle for a load in EXE
//          fwd_a/b   - EXE operand forward selects for rs/rt
//          mem_fwd_m - store data source (1 = pipeline reg, 0 = WB result)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl_hazard_unit
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [4:0] addr_rs_id,
   input  logic [4:0] addr_rt_id,
   input  logic       rs_used_id,
   input  logic       rt_used_id,
   input  logic       is_store_id,
   input  logic [4:0] regw_addr_exe,
   input  logic       wb_wen_exe,
   input  logic       mem_ren_exe,
   input  logic [4:0] regw_addr_mem,
   input  logic       wb_wen_mem,
   input  logic       mem_ren_mem,
   output logic       load_use,
   output fwd_sel_t   fwd_a,
   output fwd_sel_t   fwd_b,
   output logic       mem_fwd_m
);

   logic load_in_exe;
   logic rs_hit_exe;
   logic rt_hit_exe;
   logic store_bypass;

   assign load_in_exe = mem_ren_exe & wb_wen_exe & (regw_addr_exe != 5'd0);
   assign rs_hit_exe  = rs_used_id & (addr_rs_id == regw_addr_exe);
   assign rt_hit_exe  = rt_used_id & (addr_rt_id == regw_addr_exe);

   // Store data is only needed in MEM, by which time the load has reached
   // WB, so the store picks it up there instead of stalling.
   assign store_bypass = load_in_exe & rt_hit_exe & is_store_id;
   assign load_use     = load_in_exe & (rs_hit_exe | (rt_hit_exe & ~is_store_id));
   assign mem_fwd_m    = ~store_bypass;

   // NOTE: every combinational output gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      fwd_a = fwd_select(rs_used_id, addr_rs_id, regw_addr_exe, wb_wen_exe,
                         mem_ren_exe, regw_addr_mem, wb_wen_mem, mem_ren_mem);
      fwd_b = fwd_select(rt_used_id, addr_rt_id, regw_addr_exe, wb_wen_exe,
                         mem_ren_exe, regw_addr_mem, wb_wen_mem, mem_ren_mem);
      if (store_bypass)
         fwd_b = FROM_REG;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Pipeline controller for the 5-stage MIPS datapath.
// Inputs : clk, rst_n (async active-low), ID/EXE/MEM hazard info,
//          mem_ready, dbg_halt/dbg_step/dbg_resume run-control pulses.
// Outputs: <stage>_rst/<stage>_en synchronous controls for IF..WB,
//          exe_fwd_a_ctrl/exe_fwd_b_ctrl, mem_fwd_m forward selects,
//          halted, sticky mem_timeout, stall_cnt/flush_cnt perf counters.
// Priority: INIT > mem freeze > HALT > load-use stall > branch flush > normal.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int INIT_CYCLES = 4,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       addr_rs_id,
   input  logic [4:0]       addr_rt_id,
   input  logic             rs_used_id,
   input  logic             rt_used_id,
   input  logic             is_store_id,
   input  logic             branch_taken_id,
   input  logic [4:0]       regw_addr_exe,
   input  logic             wb_wen_exe,
   input  logic             mem_ren_exe,
   input  logic [4:0]       regw_addr_mem,
   input  logic             wb_wen_mem,
   input  logic             mem_ren_mem,
   input  logic             mem_wen_mem,
   input  logic             mem_ready,
   input  logic             dbg_halt,
   input  logic             dbg_step,
   input  logic             dbg_resume,
   output logic             if_rst,
   output logic             if_en,
   output logic             id_rst,
   output logic             id_en,
   output logic             exe_rst,
   output logic             exe_en,
   output logic             mem_rst,
   output logic             mem_en,
   output logic             wb_rst,
   output logic             wb_en,
   output logic [1:0]       exe_fwd_a_ctrl,
   output logic [1:0]       exe_fwd_b_ctrl,
   output logic             mem_fwd_m,
   output logic             halted,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int INIT_W = $clog2(INIT_CYCLES + 1);
   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   state_t            state, state_nxt;
   logic [INIT_W-1:0] init_cnt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              init_done;
   logic              freeze;
   logic              freeze_cnt_en;
   logic              stall_evt;
   logic              flush_evt;

   logic              hz_load_use;
   fwd_sel_t          hz_fwd_a;
   fwd_sel_t          hz_fwd_b;
   logic              hz_mem_fwd_m;

   pipe_hazard_ctrl_hazard_unit u_hazard (
      .addr_rs_id    (addr_rs_id),
      .addr_rt_id    (addr_rt_id),
      .rs_used_id    (rs_used_id),
      .rt_used_id    (rt_used_id),
      .is_store_id   (is_store_id),
      .regw_addr_exe (regw_addr_exe),
      .wb_wen_exe    (wb_wen_exe),
      .mem_ren_exe   (mem_ren_exe),
      .regw_addr_mem (regw_addr_mem),
      .wb_wen_mem    (wb_wen_mem),
      .mem_ren_mem   (mem_ren_mem),
      .load_use      (hz_load_use),
      .fwd_a         (hz_fwd_a),
      .fwd_b         (hz_fwd_b),
      .mem_fwd_m     (hz_mem_fwd_m)
   );

   assign init_done     = (init_cnt == INIT_W'(INIT_CYCLES - 1));
   assign freeze        = (mem_ren_mem | mem_wen_mem) & ~mem_ready;
   assign freeze_cnt_en = freeze & (state != ST_INIT);
   assign halted        = (state == ST_HALT);

   // Run-control next state. STEP leaves only after a cycle the pipeline
   // actually advanced, so a step issued into a mem wait is not lost.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_INIT: if (init_done)       state_nxt = ST_RUN;
         ST_RUN:  if (dbg_halt)        state_nxt = ST_HALT;
         ST_HALT: if (dbg_step)        state_nxt = ST_STEP;
                  else if (dbg_resume) state_nxt = ST_RUN;
         ST_STEP: if (!freeze)         state_nxt = ST_HALT;
         default:                      state_nxt = ST_INIT;
      endcase
   end

   // Stage controls in priority order; the default is the frozen/halted
   // pattern (nothing enabled, nothing reset).
   always_comb begin
      if_rst         = 1'b0;
      if_en          = 1'b0;
      id_rst         = 1'b0;
      id_en          = 1'b0;
      exe_rst        = 1'b0;
      exe_en         = 1'b0;
      mem_rst        = 1'b0;
      mem_en         = 1'b0;
      wb_rst         = 1'b0;
      wb_en          = 1'b0;
      exe_fwd_a_ctrl = hz_fwd_a;
      exe_fwd_b_ctrl = hz_fwd_b;
      mem_fwd_m      = hz_mem_fwd_m;
      stall_evt      = 1'b0;
      flush_evt      = 1'b0;

      if (state == ST_INIT) begin
         if_rst         = 1'b1;
         id_rst         = 1'b1;
         exe_rst        = 1'b1;
         mem_rst        = 1'b1;
         wb_rst         = 1'b1;
         exe_fwd_a_ctrl = FROM_REG;
         exe_fwd_b_ctrl = FROM_REG;
         mem_fwd_m      = 1'b1;
      end else if (freeze || state == ST_HALT) begin
         // everything holds
      end else if (hz_load_use) begin
         // IF/ID hold the dependent instruction; a bubble enters EXE.
         exe_rst   = 1'b1;
         exe_en    = 1'b1;
         mem_en    = 1'b1;
         wb_en     = 1'b1;
         stall_evt = 1'b1;
      end else begin
         if_en  = 1'b1;
         id_en  = 1'b1;
         exe_en = 1'b1;
         mem_en = 1'b1;
         wb_en  = 1'b1;
         if (branch_taken_id) begin
            // PC loads the target while the wrong-path IF fetch is dropped.
            id_rst    = 1'b1;
            flush_evt = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_INIT;
         init_cnt    <= '0;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else begin
         state <= state_nxt;

         if (state == ST_INIT && !init_done)
            init_cnt <= init_cnt + 1'b1;

         if (freeze_cnt_en) begin
            if (wait_cnt != WAIT_W'(MEM_TIMEOUT))
               wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1))
               mem_timeout <= 1'b1;
         end else begin
            wait_cnt <= '0;
         end

         if (stall_evt)
            stall_cnt <= stall_cnt + 1'b1;
         if (flush_evt)
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline controller for the 5-stage MIPS datapath.
- Drives every stage's synchronous rst/en pair and the forwarding selects (exe_fwd_a/b_ctrl, mem_fwd_m).
- Detects load-use hazards and inserts bubbles; squashes the wrong-path fetch on taken jumps/branches (resolved in ID).
- Freezes the pipeline on data-memory wait; provides a debug halt/step run-control FSM and stall/flush counters.

Parameters:
- INIT_CYCLES, 4, cycles all stage resets are held after rst_n deasserts
- MEM_TIMEOUT, 255, max consecutive mem-wait cycles before sticky mem_timeout
- CNT_W, 32, width of perf counters

Ports:
- clk  in  1  main clock
- rst_n  in  1  asynchronous active-low reset
- addr_rs_id, addr_rt_id  in  5 each  ID source register fields
- rs_used_id, rt_used_id  in  1 each  ID instruction reads rs/rt
- is_store_id  in  1  ID instruction is a store (rt = store data)
- branch_taken_id  in  1  ID resolves a taken branch/jump/jr this cycle
- regw_addr_exe, wb_wen_exe, mem_ren_exe  in  5/1/1  EXE-stage destination info
- regw_addr_mem, wb_wen_mem, mem_ren_mem, mem_wen_mem  in  5/1/1/1  MEM-stage info
- mem_ready  in  1  data memory completes the MEM access this cycle
- dbg_halt, dbg_step, dbg_resume  in  1 each  run-control requests (single-cycle pulses)
- if_rst, if_en, id_rst, id_en, exe_rst, exe_en, mem_rst, mem_en, wb_rst, wb_en  out  1 each  stage controls
- exe_fwd_a_ctrl, exe_fwd_b_ctrl  out  2 each  forward select
- mem_fwd_m  out  1  1 = store data from pipeline reg, 0 = from WB result
- halted  out  1  FSM in HALT
- mem_timeout  out  1  sticky error flag
- stall_cnt, flush_cnt  out  CNT_W each  perf counters

Behaviour:
- Async reset (rst_n=0): state=INIT, init counter=0, counters=0, mem_timeout=0. All *_rst=1, all *_en=0, fwd selects=FROM_REG, mem_fwd_m=1, halted=0.
- FSM states: INIT, RUN, HALT, STEP.
  - INIT: all *_rst=1 for INIT_CYCLES clocks, then RUN.
  - RUN: dbg_halt -> HALT.
  - HALT: dbg_step -> STEP; dbg_resume -> RUN; step wins if both.
  - STEP: behaves as RUN for exactly one advancing cycle (one with no mem freeze), then HALT.
- Control priority, highest first: INIT > mem freeze > HALT > load-use stall > branch flush > normal.
  - Mem freeze: (mem_ren_mem|mem_wen_mem) & ~mem_ready -> all *_en=0, all *_rst=0.
  - HALT: all *_en=0, no resets.
  - Normal: all *_en=1, all *_rst=0.
- Load-use stall condition: mem_ren_exe & wb_wen_exe & regw_addr_exe!=0, and either
  - rs_used_id & addr_rs_id==regw_addr_exe, or
  - rt_used_id & addr_rt_id==regw_addr_exe & ~is_store_id.
- Load-use stall action: if_en=0, id_en=0, exe_rst=1, mem/wb enabled. stall_cnt+1 per stall cycle.
- Store-data exception: a store whose rt matches a load in EXE does not stall; mem_fwd_m=0 instead, and exe_fwd_b_ctrl is don't-care (drive FROM_REG). Otherwise mem_fwd_m=1.
- Branch flush: branch_taken_id & not stalled/frozen/halted -> id_rst=1 (squashes IF instruction), if_en=1 so the PC loads the target. flush_cnt+1. branch_taken_id is ignored during a stall (operands not yet valid).
- Forward select per operand X in {rs, rt}, evaluated only when X is used and addr!=0, else FROM_REG:
  - EXE match & wb_wen_exe & ~mem_ren_exe -> FROM_EXE_ALUOUT.
  - else MEM match & wb_wen_mem -> FROM_MEM_DM if mem_ren_mem, else FROM_MEM_ALUOUT.
  - else FROM_REG.
  - EXE has priority over MEM.
- Timeout: a wait counter counts consecutive freeze cycles and clears on any non-freeze cycle. On reaching MEM_TIMEOUT, mem_timeout=1 (sticky until rst_n). The freeze itself continues.
- Counters wrap at 2^CNT_W.
- dbg_halt during mem freeze: takes effect immediately. Enables are already 0, so the MEM access still completes before the pipeline stays halted.

Decomposition:
- Shared package/header (alongside mips_define): forward encodings FROM_REG=0, FROM_EXE_ALUOUT=1, FROM_MEM_ALUOUT=2, FROM_MEM_DM=3; FSM state encodings.
- Sub-module hazard_unit (purely combinational: stall, forward selects, mem_fwd_m). The FSM, counters and timeout stay in the top.

Test Plan:
- Reset release -> *_rst=1 for 4 cycles, then all *_en=1, *_rst=0, state RUN.
- lw $2 in EXE (mem_ren_exe=1, regw_addr_exe=2), add reading rs=2 in ID -> one cycle if_en=id_en=0, exe_rst=1, stall_cnt=1. Next cycle exe_fwd_a_ctrl=FROM_MEM_DM.
- add $3 in EXE, sub reading rt=3 in ID -> exe_fwd_b_ctrl=FROM_EXE_ALUOUT, no stall. Same reg also in MEM -> still EXE. rt=0 -> FROM_REG.
- lw $4 in EXE, sw with rt=4 in ID -> no stall, mem_fwd_m=0.
- branch_taken_id=1, no hazard -> id_rst=1, if_en=1, flush_cnt=1. Combined with load-use stall -> no flush, stall only.
- mem_ren_mem=1, mem_ready=0 for 300 cycles -> all *_en=0 throughout, mem_timeout=1 at cycle 255.
- dbg_halt, then dbg_step (one cycle with mem_ready=0 first) -> exactly one advancing cycle, then halted=1.
